// File: rtl/ctrl_unit_pipe_pkg.sv
// ctrl_pkg: shared types and constants for the ctrl_unit_pipe decode/control stage.
//   mode_e        instruction mode field (DP / MEM / BR)
//   OP_*          data-processing and memory opcode values
//   EXE_*         execute-unit command encodings
//   cond_e        4-bit condition field encodings
//   ctrl_bundle_t packed control bundle {wbEn, memREn, memWEn, exeCmd, b, s}
//   killBundle    strips every side effect from a bundle, keeping exeCmd
//   isDefined     true when mode/opcode/S form a recognised encoding
package ctrl_pkg;

    localparam int EXE_W = 4;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10
    } mode_e;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_EOR     = 4'b0001;
    localparam logic [3:0] OP_SUB     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0100;
    localparam logic [3:0] OP_ADC     = 4'b0101;
    localparam logic [3:0] OP_SBC     = 4'b0110;
    localparam logic [3:0] OP_TST     = 4'b1000;
    localparam logic [3:0] OP_CMP     = 4'b1010;
    localparam logic [3:0] OP_ORR     = 4'b1100;
    localparam logic [3:0] OP_MOV     = 4'b1101;
    localparam logic [3:0] OP_MVN     = 4'b1111;
    localparam logic [3:0] OP_LDR_STR = 4'b0100;

    localparam logic [EXE_W-1:0] EXE_NOP = 4'h0;
    localparam logic [EXE_W-1:0] EXE_MOV = 4'h1;
    localparam logic [EXE_W-1:0] EXE_ADD = 4'h2;
    localparam logic [EXE_W-1:0] EXE_ADC = 4'h3;
    localparam logic [EXE_W-1:0] EXE_SUB = 4'h4;
    localparam logic [EXE_W-1:0] EXE_SBC = 4'h5;
    localparam logic [EXE_W-1:0] EXE_AND = 4'h6;
    localparam logic [EXE_W-1:0] EXE_ORR = 4'h7;
    localparam logic [EXE_W-1:0] EXE_EOR = 4'h8;
    localparam logic [EXE_W-1:0] EXE_MVN = 4'h9;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic             wbEn;
        logic             memREn;
        logic             memWEn;
        logic [EXE_W-1:0] exeCmd;
        logic             b;
        logic             s;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '0;

    // A condition-failed instruction still travels down the pipe but must
    // not write back, touch memory, branch or update flags.
    function automatic ctrl_bundle_t killBundle(input ctrl_bundle_t c);
        ctrl_bundle_t k;
        k        = c;
        k.wbEn   = 1'b0;
        k.memREn = 1'b0;
        k.memWEn = 1'b0;
        k.b      = 1'b0;
        k.s      = 1'b0;
        return k;
    endfunction

    // Separate from the decoder so the undefined-encoding flag only exists
    // in builds that trap on it.
    function automatic logic isDefined(input logic [1:0] mode, input logic [3:0] opcode,
                                       input logic s);
        logic ok;
        ok = 1'b0;
        case (mode)
            MODE_DP: begin
                case (opcode)
                    OP_MOV, OP_MVN, OP_ADD, OP_ADC, OP_SUB,
                    OP_SBC, OP_AND, OP_ORR, OP_EOR: ok = 1'b1;
                    OP_CMP, OP_TST:                 ok = s;
                    default:                        ok = 1'b0;
                endcase
            end
            MODE_MEM: ok = (opcode == OP_LDR_STR);
            MODE_BR:  ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ctrl_unit_pipe_cond_check.sv
// cond_check: combinational evaluation of the condition field against the flags.
//   cond_i  [3:0]  condition field
//   nzcv_i  [3:0]  status flags {N,Z,C,V}
//   pass_o         1 when the instruction should execute
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic flagN;
    logic flagZ;
    logic flagC;
    logic flagV;

    assign flagN = nzcv_i[3];
    assign flagZ = nzcv_i[2];
    assign flagC = nzcv_i[1];
    assign flagV = nzcv_i[0];

    // The 1111 encoding is reserved and treated as never-execute.
    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: pass_o = flagZ;
            COND_NE: pass_o = !flagZ;
            COND_CS: pass_o = flagC;
            COND_CC: pass_o = !flagC;
            COND_MI: pass_o = flagN;
            COND_PL: pass_o = !flagN;
            COND_VS: pass_o = flagV;
            COND_VC: pass_o = !flagV;
            COND_HI: pass_o = flagC && !flagZ;
            COND_LS: pass_o = !flagC || flagZ;
            COND_GE: pass_o = (flagN == flagV);
            COND_LT: pass_o = (flagN != flagV);
            COND_GT: pass_o = !flagZ && (flagN == flagV);
            COND_LE: pass_o = flagZ || (flagN != flagV);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: decode/control stage registering the control bundle into ID/EX.
// Optional build macro CTRL_UNDEF_TRAP_EN: when defined, undef_o flags
// unrecognised encodings; otherwise undef_o is tied low and such encodings
// leave as plain NOP bundles.
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid_i          decode inputs valid this cycle
//   in_ready_o          stage accepts input (= !stall_i)
//   mode_i, opcode_i    instruction mode / opcode fields
//   s_i, cond_i, nzcv_i S bit, condition field, status flags {N,Z,C,V}
//   stall_i, flush_i    hold the output register / discard everything
//   out_valid_o         output bundle valid
//   cmd_o [CMD_W-1:0]   {wb_en, mem_r_en, mem_w_en, exe_cmd, b, s}
//   cond_fail_o         instruction killed by its condition
//   undef_o             unrecognised encoding (trap builds only)
//   br_taken_o          taken branch in output slot
module ctrl_unit_pipe
    import ctrl_pkg::*;
#(
    parameter  int EXE_CMD_W     = 4,
    parameter  int SQUASH_CYCLES = 2,
    localparam int CMD_W         = EXE_CMD_W + 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       mode_i,
    input  logic [3:0]       opcode_i,
    input  logic             s_i,
    input  logic [3:0]       cond_i,
    input  logic [3:0]       nzcv_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    output logic [CMD_W-1:0] cmd_o,
    output logic             cond_fail_o,
    output logic             undef_o,
    output logic             br_taken_o
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

    state_e       state_q;
    logic [2:0]   squashCnt_q;
    logic         outValid_q;
    ctrl_bundle_t cmd_q;
    logic         condFail_q;
    logic         brTaken_q;

    ctrl_bundle_t decCmd;
    ctrl_bundle_t loadCmd_d;
    logic         condPass;

    cond_check uCondCheck (
        .cond_i (cond_i),
        .nzcv_i (nzcv_i),
        .pass_o (condPass)
    );

    // Decode starts from a NOP so unrecognised encodings and unused fields
    // never inherit values from a previous instruction.
    always_comb begin
        decCmd = CTRL_NOP;
        case (mode_e'(mode_i))
            MODE_DP: begin
                decCmd.wbEn = 1'b1;
                decCmd.s    = s_i;
                case (opcode_i)
                    OP_MOV: decCmd.exeCmd = EXE_MOV;
                    OP_MVN: decCmd.exeCmd = EXE_MVN;
                    OP_ADD: decCmd.exeCmd = EXE_ADD;
                    OP_ADC: decCmd.exeCmd = EXE_ADC;
                    OP_SUB: decCmd.exeCmd = EXE_SUB;
                    OP_SBC: decCmd.exeCmd = EXE_SBC;
                    OP_AND: decCmd.exeCmd = EXE_AND;
                    OP_ORR: decCmd.exeCmd = EXE_ORR;
                    OP_EOR: decCmd.exeCmd = EXE_EOR;
                    OP_CMP: begin
                        decCmd.wbEn   = 1'b0;
                        decCmd.exeCmd = EXE_SUB;
                        if (!s_i) begin
                            decCmd = CTRL_NOP;
                        end
                    end
                    OP_TST: begin
                        decCmd.wbEn   = 1'b0;
                        decCmd.exeCmd = EXE_AND;
                        if (!s_i) begin
                            decCmd = CTRL_NOP;
                        end
                    end
                    default: decCmd = CTRL_NOP;
                endcase
            end
            MODE_MEM: begin
                if (opcode_i == OP_LDR_STR) begin
                    decCmd.exeCmd = EXE_ADD;
                    decCmd.s      = s_i;
                    decCmd.wbEn   = s_i;
                    decCmd.memREn = s_i;
                    decCmd.memWEn = !s_i;
                end
            end
            MODE_BR: begin
                decCmd.b = 1'b1;
                decCmd.s = s_i;
            end
            default: decCmd = CTRL_NOP;
        endcase
    end

    assign loadCmd_d = condPass ? decCmd : killBundle(decCmd);

`ifdef CTRL_UNDEF_TRAP_EN
    logic undef_q;
    logic decUndef;

    assign decUndef = !isDefined(mode_i, opcode_i, s_i);
`endif

    // Flush beats stall; a stall freezes the register and the squash FSM.
    // Fields default to cleared on every updating edge so bubbles carry no
    // stale data. Once a taken branch arms the squash window, every accepted
    // input (branches included) is dropped until the counter runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            squashCnt_q <= '0;
            outValid_q  <= 1'b0;
            cmd_q       <= CTRL_NOP;
            condFail_q  <= 1'b0;
            brTaken_q   <= 1'b0;
`ifdef CTRL_UNDEF_TRAP_EN
            undef_q     <= 1'b0;
`endif
        end else if (flush_i || !stall_i) begin
            outValid_q <= 1'b0;
            cmd_q      <= CTRL_NOP;
            condFail_q <= 1'b0;
            brTaken_q  <= 1'b0;
`ifdef CTRL_UNDEF_TRAP_EN
            undef_q    <= 1'b0;
`endif
            if (flush_i) begin
                state_q     <= ST_RUN;
                squashCnt_q <= '0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (in_valid_i) begin
                            outValid_q <= 1'b1;
                            cmd_q      <= loadCmd_d;
                            condFail_q <= !condPass;
                            brTaken_q  <= loadCmd_d.b;
`ifdef CTRL_UNDEF_TRAP_EN
                            undef_q    <= decUndef;
`endif
                            if (loadCmd_d.b && (SQUASH_CYCLES > 0)) begin
                                state_q     <= ST_SQUASH;
                                squashCnt_q <= 3'(SQUASH_CYCLES);
                            end
                        end
                    end
                    ST_SQUASH: begin
                        if (in_valid_i) begin
                            if (squashCnt_q <= 3'd1) begin
                                state_q     <= ST_RUN;
                                squashCnt_q <= '0;
                            end else begin
                                squashCnt_q <= squashCnt_q - 3'd1;
                            end
                        end
                    end
                    default: begin
                        state_q     <= ST_RUN;
                        squashCnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign in_ready_o  = !stall_i;
    assign out_valid_o = outValid_q;
    assign cmd_o       = {cmd_q.wbEn, cmd_q.memREn, cmd_q.memWEn,
                          EXE_CMD_W'(cmd_q.exeCmd), cmd_q.b, cmd_q.s};
    assign cond_fail_o = condFail_q;
    assign br_taken_o  = brTaken_q;
`ifdef CTRL_UNDEF_TRAP_EN
    assign undef_o     = undef_q;
`else
    assign undef_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// tb_ctrl_unit_pipe: self-checking bench for ctrl_unit_pipe (SQUASH_CYCLES=2).
// Directed scenarios followed by randomized traffic, all compared against a
// table-driven behavioural model. Honours CTRL_UNDEF_TRAP_EN like the design.
module tb_ctrl_unit_pipe;

    localparam int SQ = 2;

    logic       clk;
    logic       rst_n;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [1:0] mode_i;
    logic [3:0] opcode_i;
    logic       s_i;
    logic [3:0] cond_i;
    logic [3:0] nzcv_i;
    logic       stall_i;
    logic       flush_i;
    logic       out_valid_o;
    logic [8:0] cmd_o;
    logic       cond_fail_o;
    logic       undef_o;
    logic       br_taken_o;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        int mode;
        int op;
        int sReq;
        int exe;
        bit wb;
        bit mr;
        bit mw;
        bit br;
    } row_t;

    row_t decTable[$];

    bit         expValid;
    logic [8:0] expCmd;
    bit         expCondFail;
    bit         expUndef;
    bit         expBr;
    int         squashLeft;

    ctrl_unit_pipe #(
        .EXE_CMD_W     (4),
        .SQUASH_CYCLES (SQ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mode_i      (mode_i),
        .opcode_i    (opcode_i),
        .s_i         (s_i),
        .cond_i      (cond_i),
        .nzcv_i      (nzcv_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .cmd_o       (cmd_o),
        .cond_fail_o (cond_fail_o),
        .undef_o     (undef_o),
        .br_taken_o  (br_taken_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bit refCondPass(input int c, input logic [3:0] f);
        bit n;
        bit z;
        bit cf;
        bit v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            0:       return z;
            1:       return !z;
            2:       return cf;
            3:       return !cf;
            4:       return n;
            5:       return !n;
            6:       return v;
            7:       return !v;
            8:       return cf && !z;
            9:       return !cf || z;
            10:      return n == v;
            11:      return n != v;
            12:      return !z && (n == v);
            13:      return z || (n != v);
            14:      return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void modelClear();
        expValid    = 1'b0;
        expCmd      = '0;
        expCondFail = 1'b0;
        expUndef    = 1'b0;
        expBr       = 1'b0;
    endfunction

    function automatic void modelStep(input bit v, input int md, input int op, input bit s,
                                      input int cnd, input logic [3:0] f, input bit st,
                                      input bit fl);
        bit         known;
        bit         pass;
        row_t       r;
        logic [3:0] e4;
        if (fl) begin
            modelClear();
            squashLeft = 0;
        end else if (st) begin
            return;
        end else if (squashLeft > 0) begin
            modelClear();
            if (v) squashLeft--;
        end else if (!v) begin
            modelClear();
        end else begin
            known = 1'b0;
            r     = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
            foreach (decTable[i]) begin
                if (!known && decTable[i].mode == md &&
                    (decTable[i].op < 0 || decTable[i].op == op) &&
                    (decTable[i].sReq < 0 || decTable[i].sReq == int'(s))) begin
                    known = 1'b1;
                    r     = decTable[i];
                end
            end
            pass = refCondPass(cnd, f);
            e4   = 4'(r.exe);
            expValid    = 1'b1;
            expCondFail = !pass;
            if (pass) expCmd = {r.wb, r.mr, r.mw, e4, r.br, known ? s : 1'b0};
            else      expCmd = {3'b000, e4, 2'b00};
            expBr = pass && r.br;
`ifdef CTRL_UNDEF_TRAP_EN
            expUndef = !known;
`else
            expUndef = 1'b0;
`endif
            if (expBr && SQ > 0) squashLeft = SQ;
        end
    endfunction

    task automatic applyStimulus(input string tag, input bit v, input int md, input int op,
                                 input bit s, input int cnd, input logic [3:0] f,
                                 input bit st, input bit fl);
        @(negedge clk);
        in_valid_i = v;
        mode_i     = 2'(md);
        opcode_i   = 4'(op);
        s_i        = s;
        cond_i     = 4'(cnd);
        nzcv_i     = f;
        stall_i    = st;
        flush_i    = fl;
        modelStep(v, md, op, s, cnd, f, st, fl);
        #1;
        checkOutput({tag, "_ready"}, 32'(in_ready_o), 32'(!st));
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, 32'(out_valid_o), 32'(expValid));
        checkOutput({tag, "_cmd"}, 32'(cmd_o), 32'(expCmd));
        checkOutput({tag, "_cfail"}, 32'(cond_fail_o), 32'(expCondFail));
        checkOutput({tag, "_undef"}, 32'(undef_o), 32'(expUndef));
        checkOutput({tag, "_br"}, 32'(br_taken_o), 32'(expBr));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid_o), 32'd0);
        checkOutput({tag, "_cmd"}, 32'(cmd_o), 32'd0);
        checkOutput({tag, "_cfail"}, 32'(cond_fail_o), 32'd0);
        checkOutput({tag, "_undef"}, 32'(undef_o), 32'd0);
        checkOutput({tag, "_br"}, 32'(br_taken_o), 32'd0);
    endtask

    initial begin
        int r;
        int md;
        int op;
        int cnd;

        decTable.push_back('{0, 13, -1, 1, 1'b1, 1'b0, 1'b0, 1'b0});
        decTable.push_back('{0, 15, -1, 9, 1'b1, 1'b0, 1'b0, 1'b0});
        decTable.push_back('{0,  4, -1, 2, 1'b1, 1'b0, 1'b0, 1'b0});
        decTable.push_back('{0,  5, -1, 3, 1'b1, 1'b0, 1'b0, 1'b0});
        decTable.push_back('{0,  2, -1, 4, 1'b1, 1'b0, 1'b0, 1'b0});
        decTable.push_back('{0,  6, -1, 5, 1'b1, 1'b0, 1'b0, 1'b0});
        decTable.push_back('{0,  0, -1, 6, 1'b1, 1'b0, 1'b0, 1'b0});
        decTable.push_back('{0, 12, -1, 7, 1'b1, 1'b0, 1'b0, 1'b0});
        decTable.push_back('{0,  1, -1, 8, 1'b1, 1'b0, 1'b0, 1'b0});
        decTable.push_back('{0, 10,  1, 4, 1'b0, 1'b0, 1'b0, 1'b0});
        decTable.push_back('{0,  8,  1, 6, 1'b0, 1'b0, 1'b0, 1'b0});
        decTable.push_back('{1,  4,  1, 2, 1'b1, 1'b1, 1'b0, 1'b0});
        decTable.push_back('{1,  4,  0, 2, 1'b0, 1'b0, 1'b1, 1'b0});
        decTable.push_back('{2, -1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1});

        rst_n      = 1'b0;
        in_valid_i = 1'b0;
        mode_i     = '0;
        opcode_i   = '0;
        s_i        = 1'b0;
        cond_i     = 4'he;
        nzcv_i     = '0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        modelClear();
        squashLeft = 0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("add", 1, 0, 4, 1, 14, 4'b0000, 0, 0);
        checkOutput("add_const", 32'(cmd_o), 32'(9'b100001001));

        applyStimulus("subEqFail", 1, 0, 2, 1, 0, 4'b0000, 0, 0);
        checkOutput("subEqFail_const", 32'(cmd_o), 32'(9'b000010000));
        checkOutput("subEqFail_cf", 32'(cond_fail_o), 32'd1);
        applyStimulus("subEqPass", 1, 0, 2, 1, 0, 4'b0100, 0, 0);
        checkOutput("subEqPass_const", 32'(cmd_o), 32'(9'b100010001));

        applyStimulus("branch", 1, 2, 0, 0, 14, 4'b0000, 0, 0);
        checkOutput("branch_br", 32'(br_taken_o), 32'd1);
        applyStimulus("sqAdd1", 1, 0, 4, 1, 14, 4'b0000, 0, 0);
        applyStimulus("sqIdle", 0, 0, 4, 1, 14, 4'b0000, 0, 0);
        applyStimulus("sqAdd2", 1, 0, 4, 1, 14, 4'b0000, 0, 0);
        checkOutput("sqAdd2_bubble", 32'(out_valid_o), 32'd0);
        applyStimulus("sqAdd3", 1, 0, 4, 1, 14, 4'b0000, 0, 0);
        checkOutput("sqAdd3_live", 32'(out_valid_o), 32'd1);

        applyStimulus("ldr", 1, 1, 4, 1, 14, 4'b0000, 0, 0);
        checkOutput("ldr_const", 32'(cmd_o), 32'(9'b110001001));
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall", 1, 0, 2, 1, 14, 4'b0000, 1, 0);
            checkOutput("stall_hold", 32'(cmd_o), 32'(9'b110001001));
        end
        applyStimulus("stallFlush", 1, 0, 4, 1, 14, 4'b0000, 1, 1);
        checkOutput("stallFlush_valid", 32'(out_valid_o), 32'd0);

        applyStimulus("flushBr", 1, 2, 0, 0, 14, 4'b0000, 0, 1);
        applyStimulus("afterFlushBr", 1, 0, 4, 1, 14, 4'b0000, 0, 0);

        applyStimulus("rstBr", 1, 2, 0, 0, 14, 4'b0000, 0, 0);
        applyStimulus("rstSq", 1, 0, 4, 1, 14, 4'b0000, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("asyncRst");
        modelClear();
        squashLeft = 0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("postRstAdd", 1, 0, 4, 1, 14, 4'b0000, 0, 0);
        checkOutput("postRstAdd_live", 32'(out_valid_o), 32'd1);

        applyStimulus("mode11", 1, 3, 4, 1, 14, 4'b0000, 0, 0);
        applyStimulus("cmpNoS", 1, 0, 10, 0, 14, 4'b0000, 0, 0);
        applyStimulus("condNV", 1, 0, 13, 1, 15, 4'b1111, 0, 0);

        for (int k = 0; k < 400; k++) begin
            r  = int'($urandom_range(0, 15));
            md = (r < 9) ? 0 : (r < 12) ? 1 : (r < 14) ? 2 : 3;
            op = (md == 1 && $urandom_range(0, 3) != 0) ? 4 : int'($urandom_range(0, 15));
            cnd = ($urandom_range(0, 1) == 0) ? 14 : int'($urandom_range(0, 15));
            applyStimulus("rand", $urandom_range(0, 9) < 8, md, op, 1'($urandom),
                          cnd, 4'($urandom), $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 5);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ctrl_unit_pipe.md
Name: ctrl_unit_pipe

Overview:
Next-generation decode/control stage for the ARM-subset pipeline. It decodes mode/opcode/S into the control bundle, evaluates the 4-bit condition field against the NZCV status flags, and registers the result into the ID/EX boundary. It supports stall and flush, and squashes a configurable number of shadow slots after a taken branch. Sits between the instruction-fetch/register-file read and the execute stage; drives hazard and branch-redirect logic.

Parameters:
EXE_CMD_W, 4, width of the execute-unit command field
SQUASH_CYCLES, 2, instruction slots discarded after a taken branch (0..7; 0 disables squash)
CMD_W, EXE_CMD_W+5, packed bundle width {wb_en, mem_r_en, mem_w_en, exe_cmd, b, s}; derived, not overridden

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode inputs valid this cycle
in_ready  out  1  stage accepts input; equals !stall
mode  in  2  instruction mode field
opcode  in  4  instruction opcode field
s_in  in  1  S bit
cond  in  4  condition field
nzcv  in  4  current status flags {N,Z,C,V}
stall  in  1  hazard stall; hold output register
flush  in  1  external flush (e.g. from a later stage)
out_valid  out  1  output bundle valid
cmd  out  CMD_W  registered control bundle
cond_fail  out  1  registered; instruction killed by condition
undef  out  1  registered; unrecognised encoding
br_taken  out  1  registered; taken branch in output slot

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous, active-low (rst_n). Reset clears out_valid, cmd, cond_fail, undef and br_taken to 0, squash counter to 0, FSM to RUN.
- Decode table (combinational, EXE_CMD in hex):
  - MOV 00/1101 →1; MVN 00/1111 →9; ADD 00/0100 →2; ADC 00/0101 →3; SUB 00/0010 →4; SBC 00/0110 →5; AND 00/0000 →6; ORR 00/1100 →7; EOR 00/0001 →8. All of these: wb=1.
  - CMP 00/1010, S=1 →4, wb=0. TST 00/1000, S=1 →6, wb=0.
  - LDR: mode 01/0100, S=1 →2, wb=1, mem_r=1. STR: mode 01/0100, S=0 →2, mem_w=1.
  - Branch: mode 10, b=1, exe_cmd=0.
  - Anything else: all enables 0, exe_cmd=0, undef=1.
- Outputs never retain stale fields: every field is assigned each decode.
- Condition codes:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 fails.
  - On fail: out_valid=1, cond_fail=1, wb/mem_r/mem_w/b and s forced 0.
- Latency: 1 cycle from accepted input to registered output.
- Register update priority (per clock edge):
  - flush: out_valid=0, fields cleared, squash counter cleared. Flush overrides stall.
  - else stall: everything holds, in_ready=0, and the FSM does not advance.
  - else load the decoded result if in_valid; otherwise out_valid=0.
- FSM states and transitions:
  - RUN: a loaded instruction with b=1 and condition passing sets br_taken=1 and moves to SQUASH, counter=SQUASH_CYCLES, if SQUASH_CYCLES>0.
  - SQUASH: each non-stalled cycle with in_valid=1 consumes the input as a bubble (out_valid=0) and decrements the counter; in_valid=0 cycles do not decrement. Counter reaching 0 returns to RUN.
  - A branch inside the squash window is itself squashed and never re-arms.
- Simultaneous flush+taken-branch load: flush wins; the branch is discarded and the FSM stays in/returns to RUN.

Optional Feature:
CTRL_UNDEF_TRAP_EN
- Defined: undef output is live. An undefined encoding additionally forces out_valid=1 with all enables 0, so downstream can raise an exception.
- Undefined: undef is tied 0; undefined encodings produce out_valid=1 as a plain NOP bundle.

Decomposition:
- Package ctrl_pkg holds:
  - mode_e (DP=00, MEM=01, BR=10)
  - opcode constants
  - exe_cmd constants (EXE_MOV=1 .. EXE_MVN=9)
  - cond_e
  - the packed ctrl_bundle_t struct
- Sub-module cond_check: pure combinational evaluation of cond vs nzcv → pass.

Test Plan:
- ADD (00/0100, S=1, cond=AL), in_valid=1 → next cycle out_valid=1, cmd={1,0,0,0010,0,1}, cond_fail=0.
- SUB with cond=EQ, nzcv=0000 → cond_fail=1, wb_en=0, s=0, out_valid=1; repeat with nzcv=0100 → wb_en=1, exe_cmd=0100.
- B cond=AL, followed by 3 valid ADDs, SQUASH_CYCLES=2 → br_taken=1 on the branch cycle, the next two ADDs yield out_valid=0, the third ADD is valid.
- Load LDR then assert stall 3 cycles → cmd holds {1,1,0,0010,0,1} and in_ready=0 throughout; then stall+flush together → out_valid=0 next cycle.
- rst_n low mid-SQUASH (counter=1) → all outputs 0 immediately (asynchronous); after release, the first ADD is valid (no residual squash).
- Mode 11 encoding, macro defined → out_valid=1, undef=1, cmd enables 0; macro undefined → undef=0.
